// File: rtl/dbg_slave_arb.sv
// Arbitrates NrPorts host request ports onto one fixed-latency slave port and routes
// each response back to its originating port; fixed-priority or round-robin selection.
module dbg_slave_arb #(
  parameter int unsigned NrPorts     = 2,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned ArbMode     = 0,
  parameter int unsigned ReadLatency = 1
) (
  input  logic                           IO_CLK,
  input  logic                           IO_RST_N,
  input  logic [NrPorts-1:0]             req_i,
  input  logic [NrPorts-1:0]             we_i,
  input  logic [NrPorts*4-1:0]           be_i,
  input  logic [NrPorts*AddrWidth-1:0]   addr_i,
  input  logic [NrPorts*DataWidth-1:0]   wdata_i,
  output logic [NrPorts-1:0]             gnt_o,
  output logic [NrPorts-1:0]             rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           slv_req_o,
  output logic                           slv_we_o,
  output logic [3:0]                     slv_be_o,
  output logic [AddrWidth-1:0]           slv_addr_o,
  output logic [DataWidth-1:0]           slv_wdata_o,
  input  logic [DataWidth-1:0]           slv_rdata_i,
  output logic [15:0]                    conflict_cnt_o
);

  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned SumW = IdxW + 1;

  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] idx);
    if (32'(idx) == NrPorts - 1) return '0;
    return idx + IdxW'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic multi_req(input logic [NrPorts-1:0] r);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < NrPorts; i++) n += 32'(r[i]);
    return n >= 2;
  endfunction

  logic [IdxW-1:0] rr_ptr;
  logic [IdxW-1:0] rr_base;
  logic [SumW-1:0] rr_sum;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_any;

  // Stage p0..p(ReadLatency-1): response tracking, valid and originating port
  logic            vld_p [ReadLatency];
  logic [IdxW-1:0] idx_p [ReadLatency];

  // Search starts at rr_base and wraps; fixed priority is the same search from port 0.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    rr_sum  = '0;
    rr_base = (ArbMode == 1) ? rr_ptr : '0;
    for (int unsigned k = 0; k < NrPorts; k++) begin
      rr_sum = SumW'(rr_base) + SumW'(k);
      if (rr_sum >= SumW'(NrPorts)) rr_sum = rr_sum - SumW'(NrPorts);
      if (!gnt_any && req_i[rr_sum[IdxW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_sum[IdxW-1:0];
      end
    end
  end

  assign gnt_o     = gnt_any ? (NrPorts'(1) << gnt_idx) : '0;
  assign slv_req_o = |req_i;
  assign rdata_o   = slv_rdata_i;

  // AND-OR mux of the granted port's fields; all zero when nothing is granted.
  always_comb begin
    slv_we_o    = 1'b0;
    slv_be_o    = '0;
    slv_addr_o  = '0;
    slv_wdata_o = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      if (gnt_any && gnt_idx == IdxW'(p)) begin
        slv_we_o    = we_i[p];
        slv_be_o    = be_i[p*4 +: 4];
        slv_addr_o  = addr_i[p*AddrWidth +: AddrWidth];
        slv_wdata_o = wdata_i[p*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      for (int unsigned s = 0; s < ReadLatency; s++) vld_p[s] <= 1'b0;
      rr_ptr         <= '0;
      conflict_cnt_o <= '0;
    end else begin
      vld_p[0] <= gnt_any;
      for (int unsigned s = 1; s < ReadLatency; s++) vld_p[s] <= vld_p[s-1];
      if (ArbMode == 1 && gnt_any) rr_ptr <= rr_next(gnt_idx);
      if (multi_req(req_i)) conflict_cnt_o <= sat_inc(conflict_cnt_o);
    end
  end

  // Port index is qualified by vld_p, so it needs no reset.
  always_ff @(posedge IO_CLK) begin
    idx_p[0] <= gnt_idx;
    for (int unsigned s = 1; s < ReadLatency; s++) idx_p[s] <= idx_p[s-1];
  end

  // Last stage: response handed back to the originating port
  assign rvalid_o = vld_p[ReadLatency-1] ? (NrPorts'(1) << idx_p[ReadLatency-1]) : '0;

endmodule

// File: tb/tb_dbg_slave_arb.sv
// Directed bench for dbg_slave_arb: three instances cover fixed priority (lat 1),
// round robin over 3 ports (lat 3) and reset with responses in flight (lat 2).
module tb_dbg_slave_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Instance A: 2 ports, fixed priority, latency 1
  logic        a_rst_n;
  logic [1:0]  a_req, a_we, a_gnt, a_rv;
  logic [7:0]  a_be;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_srd, a_rdata, a_saddr, a_swdata;
  logic        a_sreq, a_swe;
  logic [3:0]  a_sbe;
  logic [15:0] a_cnt;

  dbg_slave_arb #(.NrPorts(2), .ArbMode(0), .ReadLatency(1)) u_a (
    .IO_CLK(clk), .IO_RST_N(a_rst_n), .req_i(a_req), .we_i(a_we), .be_i(a_be),
    .addr_i(a_addr), .wdata_i(a_wdata), .gnt_o(a_gnt), .rvalid_o(a_rv), .rdata_o(a_rdata),
    .slv_req_o(a_sreq), .slv_we_o(a_swe), .slv_be_o(a_sbe), .slv_addr_o(a_saddr),
    .slv_wdata_o(a_swdata), .slv_rdata_i(a_srd), .conflict_cnt_o(a_cnt)
  );

  // Instance B: 3 ports, round robin, latency 3
  logic        b_rst_n;
  logic [2:0]  b_req, b_we, b_gnt, b_rv;
  logic [11:0] b_be;
  logic [95:0] b_addr, b_wdata;
  logic [31:0] b_srd, b_rdata, b_saddr, b_swdata;
  logic        b_sreq, b_swe;
  logic [3:0]  b_sbe;
  logic [15:0] b_cnt;

  dbg_slave_arb #(.NrPorts(3), .ArbMode(1), .ReadLatency(3)) u_b (
    .IO_CLK(clk), .IO_RST_N(b_rst_n), .req_i(b_req), .we_i(b_we), .be_i(b_be),
    .addr_i(b_addr), .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rv), .rdata_o(b_rdata),
    .slv_req_o(b_sreq), .slv_we_o(b_swe), .slv_be_o(b_sbe), .slv_addr_o(b_saddr),
    .slv_wdata_o(b_swdata), .slv_rdata_i(b_srd), .conflict_cnt_o(b_cnt)
  );

  // Instance C: 2 ports, round robin, latency 2
  logic        c_rst_n;
  logic [1:0]  c_req, c_we, c_gnt, c_rv;
  logic [7:0]  c_be;
  logic [63:0] c_addr, c_wdata;
  logic [31:0] c_srd, c_rdata, c_saddr, c_swdata;
  logic        c_sreq, c_swe;
  logic [3:0]  c_sbe;
  logic [15:0] c_cnt;

  dbg_slave_arb #(.NrPorts(2), .ArbMode(1), .ReadLatency(2)) u_c (
    .IO_CLK(clk), .IO_RST_N(c_rst_n), .req_i(c_req), .we_i(c_we), .be_i(c_be),
    .addr_i(c_addr), .wdata_i(c_wdata), .gnt_o(c_gnt), .rvalid_o(c_rv), .rdata_o(c_rdata),
    .slv_req_o(c_sreq), .slv_we_o(c_swe), .slv_be_o(c_sbe), .slv_addr_o(c_saddr),
    .slv_wdata_o(c_swdata), .slv_rdata_i(c_srd), .conflict_cnt_o(c_cnt)
  );

  typedef struct {
    logic [1:0]  req, we;
    logic [7:0]  be;
    logic [31:0] a0, a1, w0, w1, srd;
    logic [1:0]  e_gnt, e_rv;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t       vecs [11];
  logic [2:0] b_rq [13];
  logic [2:0] b_eg [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // req, we, be, a0, a1, w0, w1, srd | gnt, rvalid, we, be, addr, wdata, cnt
    vecs[0]  = '{2'b10, 2'b00, 8'hF0, 32'h0,   32'h40000, 32'h0,        32'h0,        32'h0,
                 2'b10, 2'b00, 1'b0, 4'hF, 32'h40000, 32'h0,        16'd0};
    vecs[1]  = '{2'b00, 2'b00, 8'h00, 32'h0,   32'h0,     32'h0,        32'h0,        32'hDEADBEEF,
                 2'b00, 2'b10, 1'b0, 4'h0, 32'h0,     32'h0,        16'd0};
    vecs[2]  = '{2'b11, 2'b00, 8'hFF, 32'h100, 32'h200,   32'h11111111, 32'h22222222, 32'h0,
                 2'b01, 2'b00, 1'b0, 4'hF, 32'h100,   32'h11111111, 16'd0};
    vecs[3]  = '{2'b11, 2'b00, 8'hFF, 32'h100, 32'h200,   32'h11111111, 32'h22222222, 32'hA0000003,
                 2'b01, 2'b01, 1'b0, 4'hF, 32'h100,   32'h11111111, 16'd1};
    vecs[4]  = '{2'b11, 2'b00, 8'hFF, 32'h100, 32'h200,   32'h11111111, 32'h22222222, 32'hA0000004,
                 2'b01, 2'b01, 1'b0, 4'hF, 32'h100,   32'h11111111, 16'd2};
    vecs[5]  = '{2'b11, 2'b00, 8'hFF, 32'h100, 32'h200,   32'h11111111, 32'h22222222, 32'hA0000005,
                 2'b01, 2'b01, 1'b0, 4'hF, 32'h100,   32'h11111111, 16'd3};
    vecs[6]  = '{2'b00, 2'b00, 8'h00, 32'h0,   32'h0,     32'h0,        32'h0,        32'hA0000006,
                 2'b00, 2'b01, 1'b0, 4'h0, 32'h0,     32'h0,        16'd4};
    vecs[7]  = '{2'b01, 2'b01, 8'h03, 32'h8,   32'h0,     32'h12345678, 32'h0,        32'h0,
                 2'b01, 2'b00, 1'b1, 4'h3, 32'h8,     32'h12345678, 16'd4};
    vecs[8]  = '{2'b00, 2'b00, 8'h00, 32'h0,   32'h0,     32'h0,        32'h0,        32'h00005A5A,
                 2'b00, 2'b01, 1'b0, 4'h0, 32'h0,     32'h0,        16'd4};
    vecs[9]  = '{2'b10, 2'b11, 8'hC3, 32'h8,   32'h44,    32'h12345678, 32'hCAFEF00D, 32'h0,
                 2'b10, 2'b00, 1'b1, 4'hC, 32'h44,    32'hCAFEF00D, 16'd4};
    vecs[10] = '{2'b00, 2'b00, 8'h00, 32'h0,   32'h0,     32'h0,        32'h0,        32'h0BADF00D,
                 2'b00, 2'b10, 1'b0, 4'h0, 32'h0,     32'h0,        16'd4};

    b_rq = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b010, 3'b001, 3'b010, 3'b011,
             3'b000, 3'b000, 3'b000};
    b_eg = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010, 3'b001, 3'b010, 3'b001,
             3'b000, 3'b000, 3'b000};

    a_rst_n = 1'b0; a_req = '0; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0; a_srd = '0;
    b_rst_n = 1'b0; b_req = '0; b_we = '0; b_be = '0; b_wdata = '0; b_srd = '0;
    b_addr  = {32'h300, 32'h200, 32'h100};
    c_rst_n = 1'b0; c_req = '0; c_we = '0; c_be = '0; c_addr = '0; c_wdata = '0; c_srd = '0;

    tick();
    tick();
    #3;
    chk("reset A gnt",    a_gnt, 0);
    chk("reset A rvalid", a_rv,  0);
    chk("reset A slvreq", a_sreq, 0);
    chk("reset A cnt",    a_cnt, 0);
    chk("reset B rvalid", b_rv,  0);
    chk("reset C rvalid", c_rv,  0);
    tick();
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

    // Instance A: table of single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      a_req   = vecs[i].req;
      a_we    = vecs[i].we;
      a_be    = vecs[i].be;
      a_addr  = {vecs[i].a1, vecs[i].a0};
      a_wdata = {vecs[i].w1, vecs[i].w0};
      a_srd   = vecs[i].srd;
      #3;
      chk($sformatf("A%0d gnt", i),    a_gnt,    vecs[i].e_gnt);
      chk($sformatf("A%0d rvalid", i), a_rv,     vecs[i].e_rv);
      chk($sformatf("A%0d slvreq", i), a_sreq,   |vecs[i].req);
      chk($sformatf("A%0d slvwe", i),  a_swe,    vecs[i].e_we);
      chk($sformatf("A%0d slvbe", i),  a_sbe,    vecs[i].e_be);
      chk($sformatf("A%0d slvaddr", i), a_saddr, vecs[i].e_addr);
      chk($sformatf("A%0d slvwdata", i), a_swdata, vecs[i].e_wdata);
      chk($sformatf("A%0d cnt", i),    a_cnt,    vecs[i].e_cnt);
      if (vecs[i].e_rv != 2'b00) chk($sformatf("A%0d rdata", i), a_rdata, vecs[i].srd);
      tick();
    end

    // Instance B: round-robin order, wrap, then mixed 1,0,1,0 grants; rvalid 3 cycles later
    for (int c = 0; c < 13; c++) begin
      logic [31:0] e_addr;
      b_req = b_rq[c];
      b_srd = 32'hB0000000 + 32'(c);
      e_addr = (b_eg[c] == 3'b001) ? 32'h100 : (b_eg[c] == 3'b010) ? 32'h200 :
               (b_eg[c] == 3'b100) ? 32'h300 : 32'h0;
      #3;
      chk($sformatf("B%0d gnt", c),     b_gnt,   b_eg[c]);
      chk($sformatf("B%0d slvaddr", c), b_saddr, e_addr);
      chk($sformatf("B%0d rvalid", c),  b_rv,    (c >= 3) ? b_eg[c-3] : 3'b000);
      if (c >= 3 && b_eg[c-3] != 3'b000) chk($sformatf("B%0d rdata", c), b_rdata, b_srd);
      tick();
    end

    // Instance C: two responses in flight when reset hits
    c_req = 2'b11;
    #3;
    chk("C0 gnt", c_gnt, 2'b01);
    tick();
    #3;
    chk("C1 gnt", c_gnt, 2'b10);
    chk("C1 cnt", c_cnt, 16'd1);
    tick();
    c_req = 2'b01;
    #3;
    chk("C2 gnt",    c_gnt, 2'b01);
    chk("C2 rvalid", c_rv,  2'b01);
    chk("C2 cnt",    c_cnt, 16'd2);
    tick();
    c_req = 2'b00;
    c_rst_n = 1'b0;
    #3;
    chk("C reset rvalid", c_rv,  2'b00);
    chk("C reset cnt",    c_cnt, 16'd0);
    tick();
    c_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk($sformatf("C post-reset%0d rvalid", c), c_rv, 2'b00);
      tick();
    end
    c_req = 2'b11;
    #3;
    chk("C ptr after reset gnt", c_gnt, 2'b01);
    chk("C cnt after reset",     c_cnt, 16'd0);
    tick();
    c_req = 2'b00;
    #3;
    chk("C cnt restart", c_cnt, 16'd1);

    // Instance A: drive conflicts until the counter must have saturated
    a_req = 2'b11; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
    for (int c = 0; c < 65600; c++) @(posedge clk);
    #1;
    #3;
    chk("A cnt saturated", a_cnt, 16'hFFFF);
    for (int c = 0; c < 5; c++) @(posedge clk);
    #4;
    chk("A cnt holds", a_cnt, 16'hFFFF);
    chk("A gnt under conflict", a_gnt, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
